// File: rtl/tank_pkg.sv
// Shared direction constants, FSM state and renderer direction encoding for the tank key path.
// Pure declarations: no latency, no flow control.
package tank_pkg;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    typedef enum logic [1:0] {
        ENC_UP    = 2'd0,
        ENC_DOWN  = 2'd1,
        ENC_LEFT  = 2'd2,
        ENC_RIGHT = 2'd3
    } dir_enc_t;

    // Priority up > down > left > right; bit order of held matches DIR_* one-hot.
    function automatic logic [3:0] sel_dir_f(input logic [3:0] held);
        if (held[3]) return DIR_UP;
        if (held[2]) return DIR_DOWN;
        if (held[1]) return DIR_LEFT;
        if (held[0]) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

    function automatic dir_enc_t dir_encode(input logic [3:0] dir);
        if (dir[3]) return ENC_UP;
        if (dir[2]) return ENC_DOWN;
        if (dir[1]) return ENC_LEFT;
        return ENC_RIGHT;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low button: 2-flop synchroniser plus stability counter, active-high level out.
// Level change appears 2+DEB_CYCLES cycles after the raw edge; no backpressure.
module key_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk_25m,
    input  logic rst,
    input  logic raw_n,
    output logic held
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          deb_n_q, deb_n_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            deb_n_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            deb_n_q <= deb_n_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], raw_n};
        deb_n_d = deb_n_q;
        cnt_d   = '0;
        // The cycle that would make DEB_CYCLES consecutive differing samples flips the level.
        if (sync_q[1] != deb_n_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_n_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign held = ~deb_n_q;

endmodule

// File: rtl/tank_key_ctrl.sv
// Debounced tank buttons to frame-aligned one-cycle move/fire commands with first-delay/auto-repeat.
// Commands appear the cycle after frame_tick; no backpressure, at most one move and one fire per frame.
module tank_key_ctrl
    import tank_pkg::*;
#(
    parameter int DEB_CYCLES   = 250000,
    parameter int REPEAT_FIRST = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic [3:0] keys_n,
    input  logic       fire_n,
    input  logic       frame_tick,
    output logic       move_vld,
    output logic [3:0] move_dir,
    output logic       fire_pulse,
    output logic [3:0] keys_held
);

    logic [3:0] held;
    logic       fire_held;
    logic [3:0] sel_dir;
    logic       fire_rise;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] move_dir_q, move_dir_d;
    logic       move_vld_q, move_vld_d;
    logic       fire_pulse_q, fire_pulse_d;
    logic       pending_q, pending_d;
    logic       fire_prev_q, fire_prev_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
            .clk_25m (clk_25m),
            .rst     (rst),
            .raw_n   (keys_n[gi]),
            .held    (held[gi])
        );
    end

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_fire (
        .clk_25m (clk_25m),
        .rst     (rst),
        .raw_n   (fire_n),
        .held    (fire_held)
    );

    assign sel_dir   = sel_dir_f(held);
    assign fire_rise = fire_held & ~fire_prev_q;

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            move_dir_q   <= DIR_NONE;
            move_vld_q   <= 1'b0;
            fire_pulse_q <= 1'b0;
            pending_q    <= 1'b0;
            fire_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            move_dir_q   <= move_dir_d;
            move_vld_q   <= move_vld_d;
            fire_pulse_q <= fire_pulse_d;
            pending_q    <= pending_d;
            fire_prev_q  <= fire_prev_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        move_dir_d   = move_dir_q;
        move_vld_d   = 1'b0;
        fire_pulse_d = 1'b0;
        pending_d    = pending_q;
        fire_prev_d  = fire_held;

        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (sel_dir != DIR_NONE) begin
                        move_vld_d = 1'b1;
                        move_dir_d = sel_dir;
                        cnt_d      = 8'(REPEAT_FIRST);
                        state_d    = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (sel_dir == DIR_NONE) begin
                        state_d = IDLE;
                    end else if (sel_dir != move_dir_q) begin
                        move_vld_d = 1'b1;
                        move_dir_d = sel_dir;
                        cnt_d      = 8'(REPEAT_FIRST);
                        state_d    = DELAY;
                    end else if (cnt_q == 8'd1) begin
                        move_vld_d = 1'b1;
                        cnt_d      = 8'(REPEAT_RATE);
                        state_d    = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
            fire_pulse_d = pending_q;
            pending_d    = 1'b0;
        end

        // An edge landing on the tick itself survives the clear and goes out next frame.
        if (fire_rise) begin
            pending_d = 1'b1;
        end
    end

    assign move_vld   = move_vld_q;
    assign move_dir   = move_dir_q;
    assign fire_pulse = fire_pulse_q;
    assign keys_held  = held;

endmodule

// File: tb/tb_tank_key_ctrl.sv
// Scenario bench for tank_key_ctrl: expected move/fire events are queued with their frame number
// and matched by a monitor as the DUT emits them.
module tb_tank_key_ctrl;

    logic       clk_25m = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys_n = 4'hF;
    logic       fire_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       move_vld;
    logic [3:0] move_dir;
    logic       fire_pulse;
    logic [3:0] keys_held;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_n = 0;
    int phase = 0;

    typedef struct {
        bit         is_fire;
        logic [3:0] dir;
        int         tick;
    } ev_t;

    ev_t exp_q[$];

    tank_key_ctrl #(
        .DEB_CYCLES   (4),
        .REPEAT_FIRST (3),
        .REPEAT_RATE  (2)
    ) dut (
        .clk_25m    (clk_25m),
        .rst        (rst),
        .keys_n     (keys_n),
        .fire_n     (fire_n),
        .frame_tick (frame_tick),
        .move_vld   (move_vld),
        .move_dir   (move_dir),
        .fire_pulse (fire_pulse),
        .keys_held  (keys_held)
    );

    always #20 clk_25m = ~clk_25m;

    // One-cycle frame_tick every 20 cycles, driven on the falling edge.
    always @(negedge clk_25m) begin
        phase = (phase == 19) ? 0 : phase + 1;
        frame_tick = (phase == 19);
    end

    always @(posedge clk_25m) begin
        if (frame_tick) tick_n++;
    end

    always @(negedge clk_25m) begin
        ev_t e;
        if (move_vld !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL move_unexpected: got move_vld=%b dir=%b after tick %0d, required no move", move_vld, move_dir, tick_n);
            end else begin
                e = exp_q.pop_front();
                if (e.is_fire || e.dir !== move_dir || e.tick != tick_n) begin
                    n_bad++;
                    $display("FAIL move_event: got move dir=%b after tick %0d, required is_fire=%0d dir=%b after tick %0d", move_dir, tick_n, e.is_fire, e.dir, e.tick);
                end
            end
        end
        if (fire_pulse !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL fire_unexpected: got fire_pulse=%b after tick %0d, required no fire", fire_pulse, tick_n);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_fire || e.tick != tick_n) begin
                    n_bad++;
                    $display("FAIL fire_event: got fire after tick %0d, required is_fire=%0d dir=%b after tick %0d", tick_n, e.is_fire, e.dir, e.tick);
                end
            end
        end
    end

    // Returns on the falling edge right after the next frame_tick has been sampled.
    task automatic sync_tick();
        int t0 = tick_n;
        for (int i = 0; i < 50 && tick_n == t0; i++) @(negedge clk_25m);
        if (tick_n == t0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_timeout: tick count stuck at %0d, required %0d", tick_n, t0 + 1);
        end
    endtask

    task automatic sync_to(input int target);
        for (int k = 0; k < 20 && tick_n < target; k++) sync_tick();
    endtask

    task automatic test_reset_values();
        repeat (3) @(negedge clk_25m);
        n_cmp++;
        if (move_vld !== 1'b0) begin n_bad++; $display("FAIL rst_move_vld: got %b, required 0", move_vld); end
        n_cmp++;
        if (move_dir !== 4'b0000) begin n_bad++; $display("FAIL rst_move_dir: got %b, required 0000", move_dir); end
        n_cmp++;
        if (fire_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_fire_pulse: got %b, required 0", fire_pulse); end
        n_cmp++;
        if (keys_held !== 4'b0000) begin n_bad++; $display("FAIL rst_keys_held: got %b, required 0000", keys_held); end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int t;
        sync_tick();
        keys_n = 4'b0111;
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        sync_to(t);
        repeat (5) @(negedge clk_25m);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (move_dir !== 4'b0000) begin n_bad++; $display("FAIL midrst_move_dir: got %b, required 0000", move_dir); end
        n_cmp++;
        if (move_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_move_vld: got %b, required 0", move_vld); end
        n_cmp++;
        if (keys_held !== 4'b0000) begin n_bad++; $display("FAIL midrst_keys_held: got %b, required 0000", keys_held); end
        repeat (3) @(negedge clk_25m);
        rst = 1'b0;
        repeat (5) @(negedge clk_25m);
        n_cmp++;
        if (keys_held !== 4'b0000) begin n_bad++; $display("FAIL rel_keys_held_5: got %b, required 0000", keys_held); end
        @(negedge clk_25m);
        n_cmp++;
        if (keys_held !== 4'b1000) begin n_bad++; $display("FAIL rel_keys_held_6: got %b, required 1000", keys_held); end
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        sync_to(t);
        keys_n = 4'hF;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL reset_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_bounce();
        int t;
        sync_tick();
        for (int i = 0; i < 20; i++) begin
            keys_n[3] = ((i / 2) % 2 == 1);
            @(negedge clk_25m);
            n_cmp++;
            if (keys_held[3] !== 1'b0) begin n_bad++; $display("FAIL bounce_held_%0d: got %b, required 0", i, keys_held[3]); end
        end
        keys_n[3] = 1'b0;
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        sync_to(t);
        keys_n = 4'hF;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL bounce_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_repeat();
        int t;
        sync_tick();
        keys_n = 4'b0111;
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        exp_q.push_back('{1'b0, 4'b1000, t + 3});
        exp_q.push_back('{1'b0, 4'b1000, t + 5});
        exp_q.push_back('{1'b0, 4'b1000, t + 7});
        sync_to(t + 7);
        keys_n = 4'hF;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL repeat_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_priority();
        int t;
        sync_tick();
        keys_n = 4'b0110;
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        sync_to(t);
        n_cmp++;
        if (move_dir !== 4'b1000) begin n_bad++; $display("FAIL prio_dir: got %b, required 1000", move_dir); end
        keys_n = 4'b1110;
        exp_q.push_back('{1'b0, 4'b0001, t + 1});
        exp_q.push_back('{1'b0, 4'b0001, t + 4});
        exp_q.push_back('{1'b0, 4'b0001, t + 6});
        repeat (8) @(negedge clk_25m);
        n_cmp++;
        if (keys_held !== 4'b0001) begin n_bad++; $display("FAIL prio_keys_held: got %b, required 0001", keys_held); end
        sync_to(t + 6);
        keys_n = 4'hF;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL prio_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_fire();
        int t;
        sync_tick();
        repeat (3) @(negedge clk_25m);
        fire_n = 1'b0;
        t = tick_n + 1;
        exp_q.push_back('{1'b1, 4'b0000, t});
        sync_to(t + 5);
        fire_n = 1'b1;
        sync_tick();
        fire_n = 1'b0;
        t = tick_n + 1;
        exp_q.push_back('{1'b1, 4'b0000, t});
        sync_to(t);
        fire_n = 1'b1;
        sync_tick();
        // Press so the debounced edge lands in the same cycle as the next frame_tick.
        repeat (13) @(negedge clk_25m);
        fire_n = 1'b0;
        t = tick_n + 2;
        exp_q.push_back('{1'b1, 4'b0000, t});
        sync_to(t);
        fire_n = 1'b1;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL fire_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_early_release();
        int t;
        sync_tick();
        keys_n = 4'b0111;
        t = tick_n + 1;
        exp_q.push_back('{1'b0, 4'b1000, t});
        sync_to(t + 1);
        keys_n = 4'hF;
        sync_to(t + 2);
        keys_n = 4'b0111;
        fire_n = 1'b0;
        exp_q.push_back('{1'b0, 4'b1000, t + 3});
        exp_q.push_back('{1'b1, 4'b0000, t + 3});
        sync_to(t + 3);
        keys_n = 4'hF;
        fire_n = 1'b1;
        sync_tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL early_missing: got %0d unseen events, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset_values();
        test_reset();
        test_bounce();
        test_repeat();
        test_priority();
        test_fire();
        test_early_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
